// File: rtl/iob_device.sv
// I/O bus device: CONO/DATAO command decode, busy/done transfer timer,
// CONI/DATAI read-back onto the wired-OR bus, priority-interrupt request.
module iob_device #(
  parameter logic [6:0]  DEVCODE     = 7'o10,
  parameter int unsigned BUSY_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  ios,
  input  logic [35:0] iob_in,
  input  logic        iob_reset,
  input  logic        iob_cono_clear,
  input  logic        iob_cono_set,
  input  logic        iob_datao_clear,
  input  logic        iob_datao_set,
  input  logic        iob_status,
  input  logic        iob_datai,
  output logic [35:0] iob_out,
  output logic [6:0]  pi_req,
  output logic [35:0] dev_data,
  output logic        dev_strobe
);

  localparam int unsigned DW = 36;
  localparam int unsigned CW = 16;
  localparam int unsigned NL = 6;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BUSY_CYCLES - 1);

  // Bit positions of the timing levels inside the level registers
  localparam int unsigned L_CC = 0;
  localparam int unsigned L_CS = 1;
  localparam int unsigned L_DC = 2;
  localparam int unsigned L_DS = 3;
  localparam int unsigned L_DI = 4;
  localparam int unsigned L_ST = 5;

  logic [6:0]    ios_q;
  logic [DW-1:0] in_q;
  logic          rst_q;
  logic [NL-1:0] lvl_q, lvl_d;

  logic [DW-1:0] dbuf_q, dbuf_n;
  logic [2:0]    pia_q, pia_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [DW-1:0] out_n;
  logic [6:0]    pi_n;
  logic          strobe_n;

  logic          sel;
  logic [NL-1:0] edg;
  logic          expire;

  // Input capture plus one-cycle-delayed copy of the levels for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ios_q <= '0;
      in_q  <= '0;
      rst_q <= 1'b0;
      lvl_q <= '0;
      lvl_d <= '0;
    end else begin
      ios_q <= ios;
      in_q  <= iob_in;
      rst_q <= iob_reset;
      lvl_q <= {iob_status, iob_datai, iob_datao_set, iob_datao_clear,
                iob_cono_set, iob_cono_clear};
      lvl_d <= lvl_q;
    end
  end

  // Next-state: timer first, then clears, then sets, then DATAI acknowledge
  always_comb begin
    dbuf_n   = dbuf_q;
    pia_n    = pia_q;
    busy_n   = busy_q;
    done_n   = done_q;
    cnt_n    = cnt_q;
    strobe_n = 1'b0;
    out_n    = '0;
    pi_n     = '0;

    sel    = (ios_q == DEVCODE);
    edg    = sel ? (lvl_q & ~lvl_d) : '0;
    expire = busy_q && (cnt_q == '0);

    if (busy_q && (cnt_q != '0)) begin
      cnt_n = cnt_q - CW'(1);
    end
    // Expiry is cancelled by anything that ends or restarts the transfer
    if (expire && !edg[L_CC] && !edg[L_DS] && !(edg[L_CS] && in_q[5])) begin
      busy_n   = 1'b0;
      done_n   = 1'b1;
      strobe_n = 1'b1;
    end
    if (edg[L_CC]) begin
      pia_n  = '0;
      busy_n = 1'b0;
      done_n = 1'b0;
    end
    if (edg[L_DC]) begin
      dbuf_n = '0;
      done_n = 1'b0;
    end
    if (edg[L_CS]) begin
      pia_n = pia_n | in_q[2:0];
      if (in_q[3]) done_n = 1'b1;
      if (in_q[4]) done_n = 1'b0;
      if (in_q[5]) begin
        busy_n = 1'b0;
        cnt_n  = '0;
      end
    end
    if (edg[L_DS]) begin
      dbuf_n = dbuf_n | in_q;
      busy_n = 1'b1;
      done_n = 1'b0;
      cnt_n  = CNT_LOAD;
    end
    if (edg[L_DI]) begin
      done_n = 1'b0;
    end

    if (done_q && (pia_q != '0)) begin
      pi_n = 7'(1) << (pia_q - 3'd1);
    end
    if (sel && lvl_q[L_ST]) begin
      out_n = DW'({busy_q, done_q, pia_q});
    end
    if (sel && lvl_q[L_DI]) begin
      out_n = out_n | dbuf_q;
    end

    if (rst_q) begin
      dbuf_n   = '0;
      pia_n    = '0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      cnt_n    = '0;
      strobe_n = 1'b0;
      out_n    = '0;
      pi_n     = '0;
    end
  end

  // Device state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbuf_q     <= '0;
      pia_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      iob_out    <= '0;
      pi_req     <= '0;
      dev_strobe <= 1'b0;
    end else begin
      dbuf_q     <= dbuf_n;
      pia_q      <= pia_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      cnt_q      <= cnt_n;
      iob_out    <= out_n;
      pi_req     <= pi_n;
      dev_strobe <= strobe_n;
    end
  end

  assign dev_data = dbuf_q;

endmodule

// File: tb/tb_iob_device.sv
// Bench for iob_device: table of CONO/DATAO commands with CONI read-back,
// strobe scoreboard, and hand sequences for transfer timing corner cases.
module tb_iob_device;

  localparam logic [6:0]  DEV = 7'o10;
  localparam int unsigned BC  = 100;

  localparam int K_CC = 0;
  localparam int K_CS = 1;
  localparam int K_DC = 2;
  localparam int K_DS = 3;
  localparam int K_IR = 4;

  typedef struct {
    int          kind;
    logic [6:0]  sel_code;
    logic [35:0] data;
    logic [35:0] exp_coni;
    logic [6:0]  exp_pi;
  } vec_t;

  typedef struct {
    logic [35:0] data;
    int          cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  ios;
  logic [35:0] iob_in;
  logic        iob_reset, iob_cono_clear, iob_cono_set;
  logic        iob_datao_clear, iob_datao_set, iob_status, iob_datai;
  logic [35:0] iob_out;
  logic [6:0]  pi_req;
  logic [35:0] dev_data;
  logic        dev_strobe;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          t_launch = 0;
  logic [35:0] mbuf     = '0;
  sb_t         sb[$];
  vec_t        vecs[12];

  iob_device #(.DEVCODE(DEV), .BUSY_CYCLES(BC)) dut (
    .clk             (clk),
    .reset           (reset),
    .ios             (ios),
    .iob_in          (iob_in),
    .iob_reset       (iob_reset),
    .iob_cono_clear  (iob_cono_clear),
    .iob_cono_set    (iob_cono_set),
    .iob_datao_clear (iob_datao_clear),
    .iob_datao_set   (iob_datao_set),
    .iob_status      (iob_status),
    .iob_datai       (iob_datai),
    .iob_out         (iob_out),
    .pi_req          (pi_req),
    .dev_data        (dev_data),
    .dev_strobe      (dev_strobe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every pulse must match the oldest pending transfer
  always @(negedge clk) begin : mon
    sb_t e;
    if (reset && dev_strobe) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d dev_data=%0o", cyc, dev_data);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || dev_data !== e.data) begin
          failures++;
          $display("FAIL strobe actual cyc=%0d data=%0o required cyc=%0d data=%0o",
                   cyc, dev_data, e.cyc, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0o required=%0o", name, act, exp);
    end
  endtask

  // One-cycle timing pulse; called and returns on a falling edge
  task automatic pulse(input int kind, input logic [6:0] s, input logic [35:0] d);
    sb_t e;
    t_launch = cyc;
    ios      = s;
    iob_in   = d;
    case (kind)
      K_CC: iob_cono_clear  = 1'b1;
      K_CS: iob_cono_set    = 1'b1;
      K_DC: iob_datao_clear = 1'b1;
      K_DS: iob_datao_set   = 1'b1;
      default: iob_reset    = 1'b1;
    endcase
    if (kind == K_IR) begin
      mbuf = '0;
      sb.delete();
    end else if (s == DEV) begin
      if (kind == K_DC) mbuf = '0;
      if (kind == K_DS) begin
        mbuf   = mbuf | d;
        e.data = mbuf;
        e.cyc  = t_launch + 2 + BC;
        sb.delete();
        sb.push_back(e);
      end
    end
    @(negedge clk);
    iob_cono_clear  = 1'b0;
    iob_cono_set    = 1'b0;
    iob_datao_clear = 1'b0;
    iob_datao_set   = 1'b0;
    iob_reset       = 1'b0;
  endtask

  // One-cycle read level; returns bus and interrupt request once registered
  task automatic rd(input logic st, input logic di, input logic [6:0] s,
                    output logic [35:0] v, output logic [6:0] p);
    ios        = s;
    iob_status = st;
    iob_datai  = di;
    @(negedge clk);
    iob_status = 1'b0;
    iob_datai  = 1'b0;
    @(negedge clk);
    v = iob_out;
    p = pi_req;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    logic [35:0] v;
    logic [6:0]  p;
    int          t0;

    reset = 1'b0; ios = DEV; iob_in = '0; iob_reset = 1'b0;
    iob_cono_clear = 1'b0; iob_cono_set = 1'b0;
    iob_datao_clear = 1'b0; iob_datao_set = 1'b0;
    iob_status = 1'b0; iob_datai = 1'b0;

    vecs[0]  = '{K_CC, DEV,      36'o0,  36'o00, 7'b0000000};
    vecs[1]  = '{K_CS, DEV,      36'o5,  36'o05, 7'b0000000};
    vecs[2]  = '{K_CS, DEV,      36'o10, 36'o15, 7'b0010000};
    vecs[3]  = '{K_CS, DEV,      36'o2,  36'o17, 7'b1000000};
    vecs[4]  = '{K_CS, DEV,      36'o20, 36'o07, 7'b0000000};
    vecs[5]  = '{K_CS, DEV,      36'o10, 36'o17, 7'b1000000};
    vecs[6]  = '{K_CS, DEV,      36'o30, 36'o07, 7'b0000000};
    vecs[7]  = '{K_CS, DEV + 1,  36'o10, 36'o07, 7'b0000000};
    vecs[8]  = '{K_CC, DEV,      36'o0,  36'o00, 7'b0000000};
    vecs[9]  = '{K_CS, DEV,      36'o11, 36'o11, 7'b0000001};
    vecs[10] = '{K_DC, DEV,      36'o0,  36'o01, 7'b0000000};
    vecs[11] = '{K_CC, DEV,      36'o0,  36'o00, 7'b0000000};

    repeat (2) @(negedge clk);
    chk("rst_iob_out", iob_out, 36'o0);
    chk("rst_pi_req", 36'(pi_req), 36'o0);
    chk("rst_dev_data", dev_data, 36'o0);
    chk("rst_strobe", 36'(dev_strobe), 36'o0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      pulse(vecs[i].kind, vecs[i].sel_code, vecs[i].data);
      rd(1'b1, 1'b0, DEV, v, p);
      chk($sformatf("vec%0d_coni", i), v, vecs[i].exp_coni);
      chk($sformatf("vec%0d_pi", i), 36'(p), 36'(vecs[i].exp_pi));
    end

    // Basic output transfer
    pulse(K_CC, DEV, 36'o0);
    pulse(K_CS, DEV, 36'o5);
    pulse(K_DC, DEV, 36'o0);
    pulse(K_DS, DEV, 36'o123456701234);
    t0 = t_launch;
    rd(1'b1, 1'b0, DEV, v, p);
    chk("xfer_busy_coni", v, 36'o25);
    wait_until(t0 + 2 + BC + 1);
    chk("xfer_strobe_seen", 36'(sb.size()), 36'o0);
    chk("xfer_dev_data", dev_data, 36'o123456701234);
    rd(1'b1, 1'b0, DEV, v, p);
    chk("xfer_done_coni", v, 36'o15);
    chk("xfer_done_pi", 36'(p), 36'(7'b0010000));

    // DATAI acknowledge
    rd(1'b0, 1'b1, DEV, v, p);
    chk("datai_data", v, 36'o123456701234);
    @(negedge clk);
    chk("datai_pi_clear", 36'(pi_req), 36'o0);
    rd(1'b1, 1'b0, DEV, v, p);
    chk("datai_coni", v, 36'o05);

    // Unselected device code
    pulse(K_DS, DEV + 1, 36'o777);
    rd(1'b0, 1'b1, DEV + 1, v, p);
    chk("unsel_datai", v, 36'o0);
    rd(1'b1, 1'b0, DEV, v, p);
    chk("unsel_coni", v, 36'o05);
    rd(1'b0, 1'b1, DEV, v, p);
    chk("unsel_buf", v, 36'o123456701234);

    // Restart landing exactly on the expiry cycle
    pulse(K_DC, DEV, 36'o0);
    pulse(K_DS, DEV, 36'o111);
    t0 = t_launch;
    wait_until(t0 + BC);
    pulse(K_DS, DEV, 36'o222);
    t0 = t_launch;
    rd(1'b1, 1'b0, DEV, v, p);
    chk("restart_coni", v, 36'o25);
    wait_until(t0 + 2 + BC + 1);
    chk("restart_strobe_seen", 36'(sb.size()), 36'o0);
    rd(1'b1, 1'b0, DEV, v, p);
    chk("restart_done_coni", v, 36'o15);

    // CONO done-clear coinciding with expiry still strobes
    pulse(K_DS, DEV, 36'o1);
    t0 = t_launch;
    wait_until(t0 + BC);
    pulse(K_CS, DEV, 36'o20);
    wait_until(t0 + 2 + BC + 1);
    chk("clrdone_strobe_seen", 36'(sb.size()), 36'o0);
    rd(1'b1, 1'b0, DEV, v, p);
    chk("clrdone_coni", v, 36'o05);
    chk("clrdone_pi", 36'(p), 36'o0);

    // IO reset mid-transfer, issued with a foreign device code
    pulse(K_DS, DEV, 36'o4);
    t0 = t_launch;
    repeat (20) @(negedge clk);
    pulse(K_IR, DEV + 1, 36'o0);
    @(negedge clk);
    chk("iorst_dev_data", dev_data, 36'o0);
    rd(1'b1, 1'b0, DEV, v, p);
    chk("iorst_coni", v, 36'o0);
    wait_until(t0 + 2 + BC + 5);

    // Asynchronous reset mid-transfer with outputs active
    pulse(K_DS, DEV, 36'o7);
    pulse(K_CS, DEV, 36'o13);
    ios        = DEV;
    iob_status = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_arst_coni", iob_out, 36'o33);
    chk("pre_arst_pi", 36'(pi_req), 36'(7'b0000100));
    @(posedge clk);
    #2 reset = 1'b0;
    sb.delete();
    mbuf = '0;
    #1;
    chk("arst_iob_out", iob_out, 36'o0);
    chk("arst_pi_req", 36'(pi_req), 36'o0);
    chk("arst_dev_data", dev_data, 36'o0);
    chk("arst_strobe", 36'(dev_strobe), 36'o0);
    @(negedge clk);
    iob_status = 1'b0;
    reset      = 1'b1;
    repeat (BC + 10) @(negedge clk);
    rd(1'b1, 1'b0, DEV, v, p);
    chk("post_arst_coni", v, 36'o0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
